// File: rtl/xbus_uart.sv
// Memory-mapped 8N1 UART slave on the core xbus: TX FIFO feeding a shifter,
// RX deserializer with a one-byte holding register, programmable bit divider.
module xbus_uart #(
    parameter logic [31:0] ADDR_BASE = 32'h1000_0000,
    parameter logic [15:0] DIV_RST   = 16'd868,
    parameter int          TX_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        xbus_as,
    input  logic        xbus_we,
    input  logic [3:0]  xbus_be,
    input  logic [31:0] xbus_addr,
    input  logic [31:0] xbus_wdata,
    output logic [31:0] xbus_rdata,
    output logic        uart_tx,
    input  logic        uart_rx,
    output logic        irq
);
    localparam int AW = $clog2(TX_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_e;

    logic          sel_s;
    logic [1:0]    idx_s;
    logic          wr_data_s;
    logic          rd_pop_s;
    logic          clr_ovr_s;
    logic          wr_div_s;
    logic          push_s;
    logic          tx_pop_s;
    logic          fifo_empty_s;
    logic          fifo_full_s;
    logic          tx_idle_s;
    logic          rx_done_s;
    logic          unused_s;

    logic [AW:0]   wr_ptr_q;
    logic [AW:0]   rd_ptr_q;
    logic [7:0]    fifo_q [TX_DEPTH];
    logic [15:0]   div_q;
    logic [15:0]   div_d;

    state_e        tx_state_q;
    logic [15:0]   tx_cnt_q;
    logic [2:0]    tx_bit_q;
    logic [7:0]    tx_sh_q;
    logic          tx_q;

    logic          rx_meta_q;
    logic          rx_s_q;
    logic          rx_prev_q;
    state_e        rx_state_q;
    logic [15:0]   rx_cnt_q;
    logic [2:0]    rx_bit_q;
    logic [7:0]    rx_sh_q;
    logic [7:0]    rx_byte_q;
    logic          rx_valid_q;
    logic          rx_ovr_q;

    assign sel_s     = xbus_as & (xbus_addr[31:4] == ADDR_BASE[31:4]);
    assign idx_s     = xbus_addr[3:2];
    assign wr_data_s = sel_s & xbus_we & (idx_s == 2'd0) & xbus_be[0];
    assign rd_pop_s  = sel_s & ~xbus_we & (idx_s == 2'd0) & xbus_be[0];
    assign clr_ovr_s = sel_s & xbus_we & (idx_s == 2'd1) & xbus_be[0] & xbus_wdata[3];
    assign wr_div_s  = sel_s & xbus_we & (idx_s == 2'd2);
    assign unused_s  = ^{xbus_addr[1:0], xbus_wdata[31:16], xbus_be[3:2]};

    // Full/empty from pointers carrying an extra wrap bit
    assign fifo_empty_s = (wr_ptr_q == rd_ptr_q);
    assign fifo_full_s  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                          (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push_s       = wr_data_s & ~fifo_full_s;
    assign tx_pop_s     = ~fifo_empty_s &
                          ((tx_state_q == S_IDLE) ||
                           ((tx_state_q == S_STOP) && (tx_cnt_q == 16'd0)));
    assign tx_idle_s    = fifo_empty_s & (tx_state_q == S_IDLE);
    assign rx_done_s    = (rx_state_q == S_STOP) && (rx_cnt_q == 16'd0) && rx_s_q;

    assign uart_tx = tx_q;
    assign irq     = rx_valid_q;

    // Read mux; zero when not selected so the bus can OR-combine slaves
    always_comb begin
        xbus_rdata = 32'h0000_0000;
        if (sel_s) begin
            case (idx_s)
                2'd0:    xbus_rdata = {23'd0, rx_valid_q, rx_byte_q};
                2'd1:    xbus_rdata = {28'd0, rx_ovr_q, rx_valid_q, tx_idle_s, fifo_full_s};
                2'd2:    xbus_rdata = {16'd0, div_q};
                default: xbus_rdata = 32'h0000_0000;
            endcase
        end else begin
            xbus_rdata = 32'h0000_0000;
        end
    end

    // Divider write with byte lanes, clamped to a usable minimum
    always_comb begin
        div_d = div_q;
        if (wr_div_s) begin
            if (xbus_be[0]) div_d[7:0] = xbus_wdata[7:0];
            else            div_d[7:0] = div_q[7:0];
            if (xbus_be[1]) div_d[15:8] = xbus_wdata[15:8];
            else            div_d[15:8] = div_q[15:8];
            if (div_d < 16'd4) div_d = 16'd4;
            else               div_d = div_d;
        end else begin
            div_d = div_q;
        end
    end

    // Divider register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) div_q <= DIV_RST;
        else      div_q <= div_d;
    end

    // TX FIFO storage and write pointer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            for (int i = 0; i < TX_DEPTH; i++) fifo_q[i] <= 8'h00;
        end else if (push_s) begin
            fifo_q[wr_ptr_q[AW-1:0]] <= xbus_wdata[7:0];
            wr_ptr_q                 <= wr_ptr_q + (AW+1)'(1);
        end
    end

    // TX FSM; the line follows the state one clock later, giving the 2-cycle start latency
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= 16'd0;
            tx_bit_q   <= 3'd0;
            tx_sh_q    <= 8'h00;
            tx_q       <= 1'b1;
            rd_ptr_q   <= '0;
        end else begin
            case (tx_state_q)
                S_START: tx_q <= 1'b0;
                S_DATA:  tx_q <= tx_sh_q[0];
                default: tx_q <= 1'b1;
            endcase
            if (tx_pop_s) begin
                tx_sh_q    <= fifo_q[rd_ptr_q[AW-1:0]];
                rd_ptr_q   <= rd_ptr_q + (AW+1)'(1);
                tx_state_q <= S_START;
                tx_cnt_q   <= div_q - 16'd1;
            end else begin
                case (tx_state_q)
                    S_START: begin
                        if (tx_cnt_q == 16'd0) begin
                            tx_state_q <= S_DATA;
                            tx_cnt_q   <= div_q - 16'd1;
                            tx_bit_q   <= 3'd0;
                        end else tx_cnt_q <= tx_cnt_q - 16'd1;
                    end
                    S_DATA: begin
                        if (tx_cnt_q == 16'd0) begin
                            tx_cnt_q <= div_q - 16'd1;
                            tx_sh_q  <= {1'b0, tx_sh_q[7:1]};
                            if (tx_bit_q == 3'd7) tx_state_q <= S_STOP;
                            else                  tx_bit_q   <= tx_bit_q + 3'd1;
                        end else tx_cnt_q <= tx_cnt_q - 16'd1;
                    end
                    S_STOP: begin
                        if (tx_cnt_q == 16'd0) tx_state_q <= S_IDLE;
                        else                   tx_cnt_q   <= tx_cnt_q - 16'd1;
                    end
                    default: tx_state_q <= S_IDLE;
                endcase
            end
        end
    end

    // RX synchronizer and deserializer FSM, sampling at mid-bit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= S_IDLE;
            rx_cnt_q   <= 16'd0;
            rx_bit_q   <= 3'd0;
            rx_sh_q    <= 8'h00;
        end else begin
            rx_meta_q <= uart_rx;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
            case (rx_state_q)
                S_IDLE: begin
                    if (rx_prev_q & ~rx_s_q) begin
                        rx_state_q <= S_START;
                        rx_cnt_q   <= {1'b0, div_q[15:1]} - 16'd1;
                    end
                end
                S_START: begin
                    if (rx_cnt_q == 16'd0) begin
                        if (rx_s_q) rx_state_q <= S_IDLE;
                        else begin
                            rx_state_q <= S_DATA;
                            rx_cnt_q   <= div_q - 16'd1;
                            rx_bit_q   <= 3'd0;
                        end
                    end else rx_cnt_q <= rx_cnt_q - 16'd1;
                end
                S_DATA: begin
                    if (rx_cnt_q == 16'd0) begin
                        rx_sh_q  <= {rx_s_q, rx_sh_q[7:1]};
                        rx_cnt_q <= div_q - 16'd1;
                        if (rx_bit_q == 3'd7) rx_state_q <= S_STOP;
                        else                  rx_bit_q   <= rx_bit_q + 3'd1;
                    end else rx_cnt_q <= rx_cnt_q - 16'd1;
                end
                S_STOP: begin
                    if (rx_cnt_q == 16'd0) rx_state_q <= S_IDLE;
                    else                   rx_cnt_q   <= rx_cnt_q - 16'd1;
                end
                default: rx_state_q <= S_IDLE;
            endcase
        end
    end

    // Holding register: a pop on the completion edge frees the slot for the new byte
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_byte_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            rx_ovr_q   <= 1'b0;
        end else begin
            if (rx_done_s && (!rx_valid_q || rd_pop_s)) begin
                rx_byte_q  <= rx_sh_q;
                rx_valid_q <= 1'b1;
            end else if (rd_pop_s) begin
                rx_valid_q <= 1'b0;
            end
            if (rx_done_s && rx_valid_q && !rd_pop_s) rx_ovr_q <= 1'b1;
            else if (clr_ovr_s)                       rx_ovr_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_xbus_uart.sv
// Directed bench for xbus_uart: register map, TX framing/FIFO, RX receive paths, reset.
module tb_xbus_uart;
    localparam logic [31:0] A_DATA = 32'h1000_0000;
    localparam logic [31:0] A_STAT = 32'h1000_0004;
    localparam logic [31:0] A_DIV  = 32'h1000_0008;
    localparam logic [31:0] A_RSV  = 32'h1000_000C;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        xbus_as = 1'b0;
    logic        xbus_we = 1'b0;
    logic [3:0]  xbus_be = 4'h0;
    logic [31:0] xbus_addr = 32'h0;
    logic [31:0] xbus_wdata = 32'h0;
    logic [31:0] xbus_rdata;
    logic        uart_tx;
    logic        uart_rx = 1'b1;
    logic        irq;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0]  rd;
    logic [39:0]  a5_obs;
    logic [199:0] b2b_obs;
    logic [47:0]  bytes6 = 48'h66_55_44_33_22_11;

    xbus_uart dut (
        .clk        (clk),
        .rst        (rst),
        .xbus_as    (xbus_as),
        .xbus_we    (xbus_we),
        .xbus_be    (xbus_be),
        .xbus_addr  (xbus_addr),
        .xbus_wdata (xbus_wdata),
        .xbus_rdata (xbus_rdata),
        .uart_tx    (uart_tx),
        .uart_rx    (uart_rx),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        @(negedge clk);
        xbus_as = 1'b1; xbus_we = 1'b1; xbus_addr = a; xbus_wdata = d; xbus_be = b;
        @(negedge clk);
        xbus_as = 1'b0; xbus_we = 1'b0; xbus_be = 4'h0;
    endtask

    task automatic bus_read(input logic [31:0] a, input logic [3:0] b, output logic [31:0] d);
        @(negedge clk);
        xbus_as = 1'b1; xbus_we = 1'b0; xbus_addr = a; xbus_be = b;
        #1 d = xbus_rdata;
        @(negedge clk);
        xbus_as = 1'b0; xbus_be = 4'h0;
    endtask

    // Serial frame on uart_rx, 8 clocks per bit
    task automatic send_rx(input logic [7:0] b, input logic stop_bit);
        logic [9:0] fb;
        fb = {stop_bit, b, 1'b0};
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            uart_rx = fb[i];
            repeat (8) @(negedge clk);
        end
        uart_rx = 1'b1;
    endtask

    // Expected uart_tx waveform, one entry per clock
    function automatic logic [63:0] frame_bits(input logic [7:0] b, input int div);
        logic [9:0]  fb;
        logic [63:0] r;
        fb = {1'b1, b, 1'b0};
        r  = 64'd0;
        for (int i = 0; i < 10 * div; i++) r[i] = fb[i / div];
        return r;
    endfunction

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tx", {63'd0, uart_tx}, 64'd1);
        check("rst_irq", {63'd0, irq}, 64'd0);
        rst = 1'b1;
        @(negedge clk);
        xbus_addr = A_STAT;
        #1 check("rdata_unsel", {32'd0, xbus_rdata}, 64'd0);
        bus_read(A_STAT, 4'h1, rd); check("rst_status", {32'd0, rd}, 64'h2);
        bus_read(A_DIV, 4'h1, rd);  check("rst_div", {32'd0, rd}, 64'h364);
        bus_read(A_RSV, 4'hF, rd);  check("reg_c_zero", {32'd0, rd}, 64'd0);
        bus_read(32'h2000_0004, 4'h1, rd); check("other_base", {32'd0, rd}, 64'd0);
        check("idle_tx", {63'd0, uart_tx}, 64'd1);

        // DIV below 4 clamps to 4
        bus_write(A_DIV, 32'h0000_0002, 4'h3);
        bus_read(A_DIV, 4'h1, rd); check("div_clamp", {32'd0, rd}, 64'h4);

        // Single frame 0xA5, DIV=4
        bus_write(A_DATA, 32'h0000_00A5, 4'h1);
        @(negedge clk);
        check("tx_before_fall", {63'd0, uart_tx}, 64'd1);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            a5_obs[i] = uart_tx;
        end
        check("frame_a5", {24'd0, a5_obs}, frame_bits(8'hA5, 4));
        bus_read(A_STAT, 4'h1, rd); check("a5_idle", {32'd0, rd}, 64'h2);

        // Six back-to-back writes: five queue up, the sixth is dropped
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            xbus_as = 1'b1; xbus_we = 1'b1; xbus_addr = A_DATA; xbus_be = 4'h1;
            xbus_wdata = {24'd0, bytes6[8*i +: 8]};
            @(negedge clk);
            if (i >= 2) b2b_obs[i-2] = uart_tx;
        end
        xbus_we = 1'b0; xbus_addr = A_STAT; xbus_wdata = 32'h0;
        #1 check("b2b_full", {32'd0, xbus_rdata}, 64'h1);
        for (int j = 4; j < 200; j++) begin
            @(negedge clk);
            xbus_as = 1'b0; xbus_be = 4'h0;
            b2b_obs[j] = uart_tx;
        end
        for (int f = 0; f < 5; f++)
            check($sformatf("b2b_frame%0d", f), {24'd0, b2b_obs[40*f +: 40]},
                  frame_bits(bytes6[8*f +: 8], 4));
        bus_read(A_STAT, 4'h1, rd); check("b2b_idle", {32'd0, rd}, 64'h2);
        check("b2b_tail_tx", {63'd0, uart_tx}, 64'd1);

        // RX, DIV=8
        bus_write(A_DIV, 32'h0000_0008, 4'h3);
        send_rx(8'h3C, 1'b1);
        check("rx_irq", {63'd0, irq}, 64'd1);
        @(negedge clk);
        xbus_as = 1'b0; xbus_addr = A_DATA;
        #1 check("rx_unsel_zero", {32'd0, xbus_rdata}, 64'd0);
        bus_read(A_DATA, 4'h1, rd); check("rx_read1", {32'd0, rd}, 64'h13C);
        bus_read(A_DATA, 4'h1, rd); check("rx_read2", {32'd0, rd}, 64'h03C);
        check("rx_irq_clr", {63'd0, irq}, 64'd0);

        // Overrun
        send_rx(8'h5A, 1'b1);
        send_rx(8'hC3, 1'b1);
        bus_read(A_STAT, 4'h1, rd); check("ovr_status", {32'd0, rd}, 64'hE);
        bus_read(A_DATA, 4'h0, rd); check("ovr_keep_first", {32'd0, rd}, 64'h15A);
        bus_write(A_STAT, 32'h0000_0008, 4'h1);
        bus_read(A_STAT, 4'h1, rd); check("ovr_cleared", {32'd0, rd}, 64'h6);
        bus_read(A_DATA, 4'h1, rd); check("ovr_pop", {32'd0, rd}, 64'h15A);
        bus_read(A_STAT, 4'h1, rd); check("ovr_empty", {32'd0, rd}, 64'h2);

        // Framing error and false start
        send_rx(8'h77, 1'b0);
        repeat (4) @(negedge clk);
        bus_read(A_STAT, 4'h1, rd); check("frame_err", {32'd0, rd}, 64'h2);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (2) @(negedge clk);
        uart_rx = 1'b1;
        repeat (30) @(negedge clk);
        bus_read(A_STAT, 4'h1, rd); check("glitch", {32'd0, rd}, 64'h2);
        check("glitch_irq", {63'd0, irq}, 64'd0);

        // Reset mid-frame
        bus_write(A_DATA, 32'h0000_0000, 4'h1);
        repeat (4) @(negedge clk);
        check("mid_tx_low", {63'd0, uart_tx}, 64'd0);
        #2 rst = 1'b0;
        #1 check("rst_async_tx", {63'd0, uart_tx}, 64'd1);
        @(negedge clk);
        rst = 1'b1;
        bus_read(A_DIV, 4'h1, rd);  check("rst2_div", {32'd0, rd}, 64'h364);
        bus_read(A_STAT, 4'h1, rd); check("rst2_status", {32'd0, rd}, 64'h2);
        repeat (10) @(negedge clk);
        check("rst2_tx", {63'd0, uart_tx}, 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/xbus_uart.md
Name: xbus_uart

Overview:
- Memory-mapped 8N1 UART slave on the core's xbus.
- Sits directly downstream of the core's xbus master port. It consumes as/we/be/addr/wdata and returns rdata combinationally in the same cycle.
- Contains a TX FIFO, a TX shifter, an RX deserializer with a one-byte holding register, and a programmable bit-period divider.

Parameters:
- ADDR_BASE, 32'h1000_0000: block selected when xbus_addr[31:4] == ADDR_BASE[31:4].
- DIV_RST, 16'd868: reset value of the DIV register (clocks per bit).
- TX_DEPTH, 4: TX FIFO entries; must be a power of 2, at least 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- xbus_as  in  1  bus access strobe.
- xbus_we  in  1  1 = write, 0 = read.
- xbus_be  in  4  byte enables.
- xbus_addr  in  32  byte address.
- xbus_wdata  in  32  write data.
- xbus_rdata  out  32  read data; combinational; 0 when not selected, so it can be OR-muxed.
- uart_tx  out  1  serial out; idle high.
- uart_rx  in  1  serial in; asynchronous.
- irq  out  1  equals rx_valid.

Behaviour:
- Access decode:
  - sel = xbus_as & (addr[31:4] == ADDR_BASE[31:4]); register index = addr[3:2].
  - All register updates and side effects occur at the rising clk edge where sel is high.
- Register map:
  - 0x0 DATA.
    - Write with be[0]: push wdata[7:0] into the TX FIFO. If the FIFO is full, the byte is dropped, evaluated on pre-edge state, even if the shifter pops the same cycle.
    - Read: returns {23'b0, rx_valid, rx_byte}. If be[0] is set, the read clears rx_valid at that edge.
  - 0x4 STATUS.
    - Read: {28'b0, rx_overrun, rx_valid, tx_idle, tx_full}, where tx_idle = FIFO empty and TX FSM in IDLE.
    - Write with be[0] and wdata[3]=1: clears rx_overrun.
  - 0x8 DIV.
    - Read: {16'b0, div}.
    - Write: be[0] updates div[7:0], be[1] updates div[15:8]. A resulting value below 4 is stored as 4.
    - A DIV change mid-frame takes effect at the next bit-counter reload.
  - 0xC: reads 0; writes ignored.
- Reset values (rst low, asynchronous): uart_tx=1, FIFO empty, rx_valid=0, rx_overrun=0, rx_byte=0, div=DIV_RST, both FSMs IDLE, irq=0. With sel low, xbus_rdata=0.
- TX FSM (IDLE, START, DATA, STOP):
  - IDLE: when the FIFO is non-empty, pop the head into the shift register and go to START on the next cycle.
  - Each bit lasts exactly div clocks. START drives 0; DATA drives 8 bits LSB first; STOP drives 1.
  - At the end of STOP: if the FIFO is non-empty, pop and enter START directly (no idle gap); otherwise go to IDLE.
  - A frame is 10*div clocks.
  - A push while the FSM is in IDLE with the FIFO empty makes uart_tx fall 2 cycles after the write edge.
- RX path:
  - uart_rx passes through a 2-flop synchronizer (rx_s); synchronizer flops reset to 1.
  - FSM states: IDLE, START, DATA, STOP.
  - IDLE: a falling rx_s moves to START.
  - START: wait div/2 (floor) clocks, then sample. If sampled 1, it is a false start: return to IDLE. Otherwise go to DATA.
  - DATA: sample every div clocks at mid-bit, 8 bits LSB first.
  - STOP: sample after div clocks.
    - Stop=0 (framing error): discard the byte and return to IDLE.
    - Stop=1 and rx_valid=0: load rx_byte and set rx_valid.
    - Stop=1 and rx_valid=1: keep the old byte and set rx_overrun.
- Simultaneous events:
  - If a DATA read pops rx_valid on the same edge a new byte completes, the new byte is loaded, rx_valid stays 1, and there is no overrun.
  - Overrun clear and overrun set on the same edge: set wins.
- FIFO: circular, with pointers one bit wider than log2(TX_DEPTH). Full means MSBs differ and the rest are equal. Pointers wrap modulo 2*TX_DEPTH.
- Reset asserted mid-frame aborts immediately; uart_tx returns to 1 asynchronously.

Test Plan:
- Reset, then read 0x4 → 32'h0000_0002, and read 0x8 → 32'h0000_0364. uart_tx=1 and irq=0 throughout.
- Write DIV=4, then write DATA=8'hA5 → uart_tx low 2 cycles after the write edge. It holds 0 for 4 clocks, then 1,0,1,0,0,1,0,1 (4 clocks each), then stop=1. tx_idle returns to 1 after 40 clocks.
- DIV=4: write 5 bytes back-to-back while idle. The first pops immediately, so the FIFO holds 4 and tx_full=1. A 6th write is dropped. uart_tx shows 5 contiguous frames (200 clocks) with no gap.
- DIV=8: drive a serial 8'h3C frame on uart_rx → rx_valid=1 and irq=1. Read 0x0 → 32'h0000_013C; the next read of 0x0 → 32'h0000_003C.
- DIV=8: send two frames without reading → STATUS reads 32'h0000_000E (overrun set, tx_idle=1) and DATA holds the first byte. Writing 0x4 with wdata=8 clears overrun.
- DIV=8: a 2-clock low glitch on uart_rx → no byte received. A frame with stop bit 0 → rx_valid stays 0. Pulling rst low mid-TX frame → uart_tx=1 within the same cycle.
